fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the decoder. It holds the program counter and issues word reads to instruction memory over a start/ready handshake. Returned words go into a 2-entry buffer, and each buffered word is presented to the decoder's `start`/`ready`/`instruction_in` port together with its PC. A branch redirect flushes the buffer and discards any in-flight memory word.

---
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage sitting directly in front of the decoder. It owns the
// program counter, fetches one word at a time from instruction memory over a
// start/ready handshake, and buffers up to two returned words (with their PCs)
// for the decoder. A branch redirect flushes the buffer; a memory request that
// is already in flight is allowed to finish, but its data is thrown away.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   enable           fetching allowed while high
//   branch_valid     single-cycle redirect request
//   branch_target    new PC for the redirect
//   mem_start        memory read request
//   mem_addr         memory read address, held for the whole request
//   mem_ready        memory read completes this cycle
//   mem_data         memory read data, valid with mem_ready
//   decoder_start    buffer head is available to the decoder
//   instruction_out  buffer head word (0 when empty)
//   pc_out           buffer head PC (0 when empty)
//   decoder_ready    decoder takes the head this cycle
module fetch_unit #(
    parameter int byte_width  = 8,
    parameter int width_instr = 4 * byte_width,
    parameter int width_addr  = 4 * byte_width,
    parameter logic [width_addr-1:0] reset_pc = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   branch_valid,
    input  logic [width_addr-1:0]  branch_target,
    output logic                   mem_start,
    output logic [width_addr-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [width_instr-1:0] mem_data,
    output logic                   decoder_start,
    output logic [width_instr-1:0] instruction_out,
    output logic [width_addr-1:0]  pc_out,
    input  logic                   decoder_ready
);

    // DRAIN waits out a request whose data must be discarded after a redirect.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [width_addr-1:0]  pc_q, pc_d;
    logic [width_addr-1:0]  mem_addr_q, mem_addr_d;
    logic [width_instr-1:0] word_q [2];
    logic [width_instr-1:0] word_d [2];
    logic [width_addr-1:0]  tag_q [2];
    logic [width_addr-1:0]  tag_d [2];
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic [1:0]             count_q, count_d;
    logic [1:0]             count_after_push;
    logic                   push;
    logic                   pop;
    logic                   flush;

    // State, PC and request address sequencing.
    // In REQ the PC equals the outstanding request address, so a completion
    // advances both together; in DRAIN the PC already holds the branch target
    // while mem_addr keeps the abandoned address until memory answers.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        mem_addr_d       = mem_addr_q;
        push             = 1'b0;
        flush            = branch_valid;
        pop              = (count_q != 2'd0) && decoder_ready;
        // Occupancy if this cycle pushes; only meaningful in REQ, where the
        // buffer is never full, so the sum cannot overflow.
        count_after_push = count_q + 2'd1 - {1'b0, pop};

        case (state_q)
            IDLE: begin
                if (branch_valid) begin
                    pc_d = branch_target;
                end else if (enable && (count_q < 2'd2)) begin
                    state_d    = REQ;
                    mem_addr_d = pc_q;
                end
            end
            REQ: begin
                if (branch_valid) begin
                    pc_d    = branch_target;
                    state_d = mem_ready ? IDLE : DRAIN;
                end else if (mem_ready) begin
                    push       = 1'b1;
                    pc_d       = pc_q + width_addr'(4);
                    mem_addr_d = pc_q + width_addr'(4);
                    state_d    = (enable && (count_after_push < 2'd2)) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (branch_valid) begin
                    pc_d = branch_target;
                end
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Two-entry FIFO bookkeeping. A flush wins over any same-cycle pop: the
    // popped word still counts as delivered, and the buffer ends up empty.
    always_comb begin
        word_d = word_q;
        tag_d  = tag_q;
        if (push) begin
            word_d[wr_ptr_q] = mem_data;
            tag_d[wr_ptr_q]  = mem_addr_q;
        end

        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= reset_pc;
            mem_addr_q <= reset_pc;
            word_q     <= '{default: '0};
            tag_q      <= '{default: '0};
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            word_q     <= word_d;
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output
    // within the same cycle.
    assign mem_start       = (state_q != IDLE);
    assign mem_addr        = mem_addr_q;
    assign decoder_start   = (count_q != 2'd0);
    assign instruction_out = decoder_start ? word_q[rd_ptr_q] : '0;
    assign pc_out          = decoder_start ? tag_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit. A transaction-level model (an outstanding
// request record, a next-fetch PC and a queue of {word, pc} entries) predicts
// every output; a negedge process compares the DUT against it each cycle.
// Directed sequences add hand-computed literal expectations, followed by a
// long randomized run with occasional asynchronous resets.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        mem_start;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data;
    logic        decoder_start;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        decoder_ready = 1'b0;

    // Directed runs return a word derived from the address so the literal
    // expectations are easy to write; random runs return random words.
    logic        dir_mode = 1'b1;
    logic [31:0] rand_data = '0;
    assign mem_data = dir_mode ? (32'h9100_0000 | (mem_addr << 8)) : rand_data;

    int tests = 0;
    int fails = 0;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .branch_valid    (branch_valid),
        .branch_target   (branch_target),
        .mem_start       (mem_start),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_data        (mem_data),
        .decoder_start   (decoder_start),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .decoder_ready   (decoder_ready)
    );

    always #5 clk = ~clk;

    // Reference model state.
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_q [$];
    entry_t      m_entry;
    bit          m_req = 1'b0;
    bit          m_discard = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_pc = '0;
    int          m_before;
    bit          m_pop;
    bit          m_done;
    bit          m_push;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Model update: what happens to the request, the PC and the buffer when
    // the clock edge samples the current inputs.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_req     = 1'b0;
            m_discard = 1'b0;
            m_addr    = 32'h0;
            m_pc      = 32'h0;
        end else begin
            m_before = m_q.size();
            m_pop    = (m_before != 0) && decoder_ready;
            m_done   = m_req && mem_ready;
            m_push   = m_done && !m_discard && !branch_valid;

            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                m_entry.word = mem_data;
                m_entry.pc   = m_addr;
                m_q.push_back(m_entry);
                m_pc = m_addr + 32'd4;
            end
            if (branch_valid) begin
                m_q.delete();
                m_pc = branch_target;
            end

            if (m_req && !m_done) begin
                if (branch_valid) m_discard = 1'b1;
            end else if (m_push) begin
                m_req  = enable && (m_q.size() < 2);
                m_addr = m_pc;
            end else if (m_done) begin
                m_req     = 1'b0;
                m_discard = 1'b0;
            end else if (!branch_valid && enable && (m_before < 2)) begin
                m_req     = 1'b1;
                m_discard = 1'b0;
                m_addr    = m_pc;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset) begin
            check_output("mem_start", {31'b0, mem_start}, {31'b0, m_req});
            if (m_req) check_output("mem_addr", mem_addr, m_addr);
            check_output("decoder_start", {31'b0, decoder_start},
                         {31'b0, (m_q.size() != 0)});
            check_output("instruction_out", instruction_out,
                         (m_q.size() != 0) ? m_q[0].word : 32'h0);
            check_output("pc_out", pc_out, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " mem_start"}, {31'b0, mem_start}, 32'h0);
        check_output({tag, " mem_addr"}, mem_addr, 32'h0);
        check_output({tag, " decoder_start"}, {31'b0, decoder_start}, 32'h0);
        check_output({tag, " instruction_out"}, instruction_out, 32'h0);
        check_output({tag, " pc_out"}, pc_out, 32'h0);
    endtask

    task automatic reset_dut();
        enable        = 1'b0;
        branch_valid  = 1'b0;
        mem_ready     = 1'b0;
        decoder_ready = 1'b0;
        reset         = 1'b0;
        step();
        step();
        reset = 1'b1;
        check_reset_values("reset");
    endtask

    // Asynchronous reset pulse taken between clock edges.
    task automatic mid_reset(input string tag);
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic apply_stimulus();
        enable        = ($urandom_range(0, 9) != 0);
        branch_valid  = !branch_valid && ($urandom_range(0, 11) == 0);
        branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                    : ($urandom & 32'hFFFF_FFFC);
        mem_ready     = ($urandom_range(0, 2) != 0);
        decoder_ready = ($urandom_range(0, 2) != 0);
        rand_data     = $urandom;
    endtask

    initial begin
        // Reset and linear fetch.
        reset_dut();
        enable = 1'b1; mem_ready = 1'b1; decoder_ready = 1'b1;
        step();
        check_output("lin first mem_start", {31'b0, mem_start}, 32'h1);
        check_output("lin first mem_addr", mem_addr, 32'h0);
        check_output("lin first decoder_start", {31'b0, decoder_start}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("lin decoder_start", {31'b0, decoder_start}, 32'h1);
            check_output("lin pc_out", pc_out, 32'(4 * i));
            check_output("lin instruction_out", instruction_out,
                         32'h9100_0000 + 32'(i * 32'h400));
        end

        // Backpressure: two pushes fill the buffer, head holds.
        reset_dut();
        enable = 1'b1; mem_ready = 1'b1; decoder_ready = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 2; i++) begin
            check_output("bp mem_start", {31'b0, mem_start}, 32'h0);
            check_output("bp instruction_out", instruction_out, 32'h9100_0000);
            check_output("bp pc_out", pc_out, 32'h0);
            step();
        end
        decoder_ready = 1'b1;
        step();
        check_output("bp second pc_out", pc_out, 32'h4);
        check_output("bp second instruction_out", instruction_out, 32'h9100_0400);

        // Branch while a slow request is outstanding.
        reset_dut();
        enable = 1'b1; mem_ready = 1'b0; decoder_ready = 1'b1;
        step();
        branch_valid = 1'b1; branch_target = 32'h100;
        step();
        branch_valid = 1'b0;
        check_output("drain mem_start", {31'b0, mem_start}, 32'h1);
        check_output("drain mem_addr", mem_addr, 32'h0);
        step();
        check_output("drain mem_addr held", mem_addr, 32'h0);
        mem_ready = 1'b1;
        step();
        check_output("drain done mem_start", {31'b0, mem_start}, 32'h0);
        check_output("drain done decoder_start", {31'b0, decoder_start}, 32'h0);
        step();
        check_output("redirect mem_addr", mem_addr, 32'h100);
        step();
        check_output("redirect pc_out", pc_out, 32'h100);
        check_output("redirect instruction_out", instruction_out, 32'h9101_0000);

        // Pop and branch in the same cycle with a full buffer.
        reset_dut();
        enable = 1'b1; mem_ready = 1'b1; decoder_ready = 1'b0;
        step(); step(); step();
        check_output("full decoder_start", {31'b0, decoder_start}, 32'h1);
        decoder_ready = 1'b1; branch_valid = 1'b1; branch_target = 32'h40;
        step();
        branch_valid = 1'b0;
        check_output("popbr decoder_start", {31'b0, decoder_start}, 32'h0);
        step();
        check_output("popbr mem_addr", mem_addr, 32'h40);

        // PC wrap through the top of the address space.
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_valid = 1'b0;
        step();
        check_output("wrap first mem_addr", mem_addr, 32'hFFFF_FFFC);
        step();
        check_output("wrap second mem_addr", mem_addr, 32'h0);
        check_output("wrap pc_out", pc_out, 32'hFFFF_FFFC);
        mem_ready = 1'b0;
        step();
        mid_reset("midreq");

        // Randomized run.
        dir_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus();
            step();
            if (i % 1000 == 500) mid_reset("random reset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
